// File: rtl/pcs_tx_gearbox_pkg.sv
// rtl/pcs_tx_gearbox_pkg.sv - shared PCS constants and block type for the TX gearbox
package pcs_tx_gearbox_pkg;

    localparam int BLOCK_W = 66;
    localparam int DATA_W  = 64;
    localparam int SEQ_MAX = 32;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  head;
    } pcs_block_t;

endpackage

// File: rtl/pcs_tx_gearbox_shift.sv
// rtl/pcs_tx_gearbox_shift.sv - combinational packer merging a 66-bit block onto the buffered residue
module gearbox_shift #(
    parameter int BLOCK_W = 66,
    parameter int DATA_W  = 64
) (
    input  logic [BLOCK_W-1:0] i_blk,
    input  logic [DATA_W-1:0]  i_buf,
    input  logic [6:0]         i_fill,
    output logic [DATA_W-1:0]  o_word,
    output logic [DATA_W-1:0]  o_buf
);

    // Residue bits above the fill level are always zero, so an OR merges cleanly.
    logic [2*DATA_W-1:0] w_cat;

    assign w_cat  = ({{(2*DATA_W-BLOCK_W){1'b0}}, i_blk} << i_fill)
                  | {{DATA_W{1'b0}}, i_buf};
    assign o_word = w_cat[DATA_W-1:0];
    assign o_buf  = w_cat[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/pcs_tx_gearbox.sv
// rtl/pcs_tx_gearbox.sv - 66b-to-64b TX gearbox; PCS_TX_GEARBOX_CNT_EN adds blk_cnt_o accept counter
module pcs_tx_gearbox
    import pcs_tx_gearbox_pkg::*;
#(
    parameter int BLOCK_W = pcs_tx_gearbox_pkg::BLOCK_W,
    parameter int DATA_W  = pcs_tx_gearbox_pkg::DATA_W,
    parameter int SEQ_MAX = pcs_tx_gearbox_pkg::SEQ_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        head_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
`ifdef PCS_TX_GEARBOX_CNT_EN
    output logic [31:0]       blk_cnt_o,
`endif
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o
);

    logic [5:0]        r_seq;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_err;

    pcs_block_t        w_blk;
    logic              w_ready;
    logic [6:0]        w_fill;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_nbuf;

    assign w_blk   = '{data: data_i, head: head_i};
    assign w_ready = (r_seq != 6'(SEQ_MAX));
    assign w_fill  = {r_seq, 1'b0};

    gearbox_shift #(
        .BLOCK_W (BLOCK_W),
        .DATA_W  (DATA_W)
    ) u_shift (
        .i_blk  (w_blk),
        .i_buf  (r_buf),
        .i_fill (w_fill),
        .o_word (w_word),
        .o_buf  (w_nbuf)
    );

    // Sequence value SEQ_MAX is the drain slot: the buffer is exactly one full word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq   <= '0;
            r_buf   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (!w_ready) begin
            r_data  <= r_buf;
            r_buf   <= '0;
            r_seq   <= '0;
            r_valid <= 1'b1;
            r_err   <= 1'b0;
        end else if (valid_i) begin
            r_data  <= w_word;
            r_buf   <= w_nbuf;
            r_seq   <= r_seq + 6'd1;
            r_valid <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b1;
        end
    end

`ifdef PCS_TX_GEARBOX_CNT_EN
    logic [31:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_ready && valid_i) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign blk_cnt_o = r_cnt;
`endif

    assign ready_o = w_ready;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign err_o   = r_err;

endmodule

// File: doc/pcs_tx_gearbox.md
# pcs_tx_gearbox

Transmit gearbox and sequencer for the 64b/66b PCS path. It accepts one 66-bit block per handshake from the encoder/scrambler stage and packs the blocks into a continuous stream of 64-bit words for the PMA/serializer. Every 33rd cycle it withholds `ready_o` so that 32 blocks (2112 bits) drain as 33 words. It is the only block that throttles the scrambler: the scrambler advances its state only on cycles where this block accepts data.

## Interface
Parameters:
- `BLOCK_W`, 66: input block width; header plus payload.
- `DATA_W`, 64: output word width; also the payload width.
- `SEQ_MAX`, 32: blocks per gearbox period; the pause cycle falls at this sequence value.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `head_i`  in  2  sync header; `2'b01` = data, `2'b10` = control.
- `data_i`  in  64  scrambled payload.
- `valid_i`  in  1  block present on `head_i`/`data_i`.
- `ready_o`  out  1  gearbox accepts a block this cycle.
- `data_o`  out  64  packed line word; transmitted LSB first.
- `valid_o`  out  1  `data_o` holds a valid line word.
- `err_o`  out  1  one-cycle pulse on an upstream underrun.

## Operation
- Block bit order is `blk = {data_i, head_i}`: the header occupies bits [1:0] and is sent first.
- Sequence counter `seq_q` is 6 bits wide and spans 0..32. Buffer `buf_q` is 64 bits wide. Fill level is `2*seq_q` bits, stored LSB-aligned.
- `ready_o = (seq_q != SEQ_MAX)`. This is combinational from `seq_q` only and never depends on `valid_i`.
- Accept (`valid_i && ready_o`) while `seq_q = k` (0..31):
  - next `data_o = {blk[63-2k:0], buf_q[2k-1:0]}`;
  - next `buf_q = blk[65:64-2k]`, which is 2k+2 bits, zero-extended;
  - `seq_q <= k+1`;
  - `valid_o <= 1`.
- Pause (`seq_q = 32`):
  - next `data_o = buf_q`;
  - `buf_q <= 0`, `seq_q <= 0`, `valid_o <= 1`;
  - `valid_i` is ignored.
- Underrun (`ready_o && !valid_i`):
  - `seq_q` and `buf_q` hold;
  - `valid_o <= 0`;
  - `data_o` holds its previous value;
  - `err_o <= 1` for one cycle.
- States are implied by `seq_q`: FILL (0..31) and DRAIN (32). The only transitions are FILL(k) to FILL(k+1) on accept, FILL(31) to DRAIN on accept, and DRAIN to FILL(0) unconditionally.

## Timing
- Output registers are `data_o`, `valid_o` and `err_o`. Latency is 1 cycle from accept to the corresponding word on `data_o`.
- Reset values:
  - `seq_q = 0`, `buf_q = 0`;
  - `data_o = 0`, `valid_o = 0`, `err_o = 0`;
  - `ready_o = 1`.
- Reset asserted mid-period discards the partial buffer. The first block after release is aligned at fill 0.
- Steady state with `valid_i` held high: `ready_o` is low exactly 1 cycle in 33, and `valid_o` stays high continuously from cycle 1 after the first accept.
- The upstream scrambler advances only on cycles where `valid_i && ready_o`.

## Configuration
- `PCS_TX_GEARBOX_CNT_EN`
  - Defined: adds output `blk_cnt_o[31:0]`, reset to 0, incremented on every accept and wrapping at 2^32.
  - Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared PCS package holds:
  - `BLOCK_W`, `DATA_W`, `SEQ_MAX` constants;
  - sync header constants `SYNC_DATA = 2'b01` and `SYNC_CTRL = 2'b10`;
  - typedef `pcs_block_t` as a 66-bit packed struct `{data[63:0], head[1:0]}`.
- One sub-module, `gearbox_shift`: combinational packer taking `blk`, `buf_q` and fill level, producing the next word and the next buffer. The top level keeps the counter, handshake and registers.

## Test plan
- Reset, then block `head=01`, `data=0` → `ready_o=1`; 1 cycle later `data_o=64'h1`, `valid_o=1`.
- Follow with `head=10`, `data=64'hFFFF_FFFF_FFFF_FFFF` → `data_o=64'hFFFF_FFFF_FFFF_FFF8`.
- 32 consecutive blocks `head=01`, `data=64'hA5A5_A5A5_A5A5_A5A5` → `ready_o=0` on cycle 33 only. The 33-word output concatenated equals the 32 input blocks bit-exact, and `valid_o` is never low.
- Drop `valid_i` for 3 cycles at `seq_q=7` → `err_o` pulses 3 times, `valid_o=0` for 3 cycles, and the stream resumes aligned with no bit lost.
- Assert `rst` at `seq_q=20` → all outputs return to their reset values. The next block `head=01`, `data=0` yields `data_o=64'h1`.
- With `PCS_TX_GEARBOX_CNT_EN`, 100 accepts including 3 pause cycles → `blk_cnt_o=100`.
